instr_encoder_loader: RTL and testbench

- Reverse direction of the 16-bit instruction decoder: accepts decoded instruction fields over a valid/ready stream and packs them into 16-bit instruction words.
- Writes the words sequentially into instruction memory through a registered write port.
- Sits between the host/boot program source and the instruction memory. Rejects unencodable tuples and counts them.

---
 rtl/instr_encoder_loader.sv | 135 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into instruction memory.
// Optional running checksum output when INSTR_ENCODER_CHECKSUM_EN is defined.
//   state  | meaning
//   IDLE   | no session, waiting for start
//   LOAD   | accepting tuples, writing words
//   FULL   | DEPTH words written, waiting for finish
//   DONE   | session closed, waiting for start
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count,
`ifdef INSTR_ENCODER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic              accept;
  logic              reject;
  logic              session_start;
  logic [15:0]       enc;
  logic [ADDR_W:0]   wc_next;

  assign in_ready      = (state_q == S_LOAD);
  assign busy          = (state_q == S_LOAD) || (state_q == S_FULL);
  assign done          = (state_q == S_DONE);
  assign accept        = in_valid && in_ready;
  assign session_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign wc_next       = word_count + (ADDR_W+1)'(1);
  // Reset has priority even over a write already staged for this cycle.
  assign imem_we       = we_q && rst_n;

  always_comb begin
    enc    = '0;
    reject = 1'b0;
    case (in_class)
      2'b00: begin
        enc    = {2'b00, in_op[0], in_rd, in_rs1, in_imm[6:0]};
        reject = !((&in_imm[15:6]) || (~|in_imm[15:6]));
      end
      2'b01: enc = {2'b01, in_op, 1'b0, in_rd, in_rs1, in_rs2};
      2'b10: begin
        case (in_op[2:0])
          3'b111:  enc = 16'hB800;
          3'b110:  enc = {2'b10, 3'b110, 6'b000000, in_rd, 2'b00};
          default: enc = {2'b10, in_op[2:0], in_rs1, in_rs2, in_rd, 2'b00};
        endcase
      end
      default: reject = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (finish)                                        state_d = S_DONE;
        else if (accept && !reject && wc_next == DEPTH_W)  state_d = S_FULL;
      end
      S_FULL: if (finish) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      if (session_start) begin
        base_q     <= base_addr;
        err        <= 1'b0;
        err_count  <= '0;
        word_count <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end
      if (accept) begin
        if (reject) begin
          err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          we_q       <= 1'b1;
          imem_addr  <= base_q + word_count[ADDR_W-1:0];
          imem_wdata <= enc;
          word_count <= wc_next;
`ifdef INSTR_ENCODER_CHECKSUM_EN
          checksum   <= checksum + enc;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus randomized traffic
// compared against a behavioural session model. Honours INSTR_ENCODER_CHECKSUM_EN.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_FULL = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              rst_n, start, finish, in_valid;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        in_class;
  logic [3:0]        in_op;
  logic [2:0]        in_rd, in_rs1, in_rs2;
  logic [15:0]       in_imm;
  logic              in_ready, imem_we, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [7:0]        err_count;
  logic [ADDR_W:0]   word_count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int n_vec = 0;
  int n_err = 0;

  int m_st, m_base, m_wc, m_errc, m_addr, m_wdata, m_ck;
  bit m_we, m_err;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_count(err_count),
`ifdef INSTR_ENCODER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic bit model_reject();
    int simm;
    simm = int'($signed(in_imm));
    if (in_class == 2'd3) return 1'b1;
    if (in_class == 2'd0 && (simm < -64 || simm > 63)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_encode();
    int cond;
    cond = int'(in_op) % 8;
    case (in_class)
      2'd0: return int'(in_op[0]) * 8192 + int'(in_rd) * 1024 + int'(in_rs1) * 128 + (int'(in_imm) % 128);
      2'd1: return 16384 + int'(in_op) * 1024 + int'(in_rd) * 64 + int'(in_rs1) * 8 + int'(in_rs2);
      default: begin
        if (cond == 7) return 16'hB800;
        if (cond == 6) return 32768 + 6 * 2048 + int'(in_rd) * 4;
        return 32768 + cond * 2048 + int'(in_rs1) * 256 + int'(in_rs2) * 32 + int'(in_rd) * 4;
      end
    endcase
  endfunction

  task automatic model_step();
    bit acc, rej;
    if (!rst_n) begin
      m_st = M_IDLE; m_base = 0; m_wc = 0; m_errc = 0; m_addr = 0; m_wdata = 0;
      m_ck = 0; m_we = 0; m_err = 0;
      return;
    end
    acc  = (m_st == M_LOAD) && in_valid;
    rej  = model_reject();
    m_we = 0;
    case (m_st)
      M_IDLE, M_DONE: if (start) begin
        m_st = M_LOAD; m_base = int'(base_addr); m_wc = 0; m_err = 0; m_errc = 0; m_ck = 0;
      end
      M_LOAD: begin
        if (acc) begin
          if (rej) begin
            m_err = 1;
            if (m_errc < 255) m_errc++;
          end else begin
            m_we = 1;
            m_addr = (m_base + m_wc) % 256;
            m_wdata = model_encode();
            m_wc++;
            m_ck = (m_ck + m_wdata) % 65536;
          end
        end
        if (finish) m_st = M_DONE;
        else if (acc && !rej && m_wc == DEPTH) m_st = M_FULL;
      end
      M_FULL: if (finish) m_st = M_DONE;
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; finish = 0; in_valid = 0; base_addr = '0;
    in_class = '0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
  endtask

  task automatic set_tuple(input int cls, input int op, input int rd, input int rs1,
                           input int rs2, input int imm);
    in_valid = 1; in_class = 2'(cls); in_op = 4'(op); in_rd = 3'(rd);
    in_rs1 = 3'(rs1); in_rs2 = 3'(rs2); in_imm = 16'(imm);
  endtask

  task automatic begin_session(input int base);
    start = 1; base_addr = 8'(base);
    cycle();
    start = 0;
  endtask

  task automatic end_session();
    in_valid = 0; finish = 1;
    cycle();
    finish = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cycle(); cycle();
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata, busy, done, err, err_count, word_count, in_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h busy=%b done=%b err=%b errc=%0d wc=%0d rdy=%b, all required 0",
               imem_we, imem_addr, imem_wdata, busy, done, err, err_count, word_count, in_ready);
    end
    rst_n = 1;
    cycle();
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_load_basic();
    begin_session(16'h10);
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || word_count !== 9'd0) begin
      n_err++; $display("FAIL basic_load_state: busy=%b rdy=%b wc=%0d, required 1 1 0", busy, in_ready, word_count);
    end
    set_tuple(0, 0, 3, 5, 0, 16'hFFFE);
    cycle();
    in_valid = 0;
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h10 || imem_wdata !== 16'h0EFE || word_count !== 9'd1) begin
      n_err++;
      $display("FAIL basic_write: we=%b addr=%h wdata=%h wc=%0d, required 1 10 0efe 1",
               imem_we, imem_addr, imem_wdata, word_count);
    end
    cycle();
    n_vec++;
    if (imem_we !== 1'b0) begin n_err++; $display("FAIL basic_single_pulse: we=%b, required 0", imem_we); end
    end_session();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h2885; exp_w[1] = 16'h4853; exp_w[2] = 16'h8CB8;
    begin_session(16'h20);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_tuple(0, 1, 2, 1, 0, 5);
        1: set_tuple(1, 2, 1, 2, 3, 0);
        default: set_tuple(2, 1, 6, 4, 5, 0);
      endcase
      cycle();
      n_vec++;
      if (imem_we !== 1'b1 || imem_addr !== 8'(8'h20 + i) || imem_wdata !== exp_w[i]) begin
        n_err++;
        $display("FAIL b2b_word%0d: we=%b addr=%h wdata=%h, required 1 %h %h",
                 i, imem_we, imem_addr, imem_wdata, 8'(8'h20 + i), exp_w[i]);
      end
    end
    end_session();
  endtask

  task automatic test_jump_special();
    begin_session(16'h40);
    set_tuple(2, 6, 7, 5, 5, 0);
    cycle();
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h40 || imem_wdata !== 16'hB01C) begin
      n_err++; $display("FAIL jump_jmp: we=%b addr=%h wdata=%h, required 1 40 b01c", imem_we, imem_addr, imem_wdata);
    end
    set_tuple(2, 4'h7 | ($urandom_range(0, 1) << 3), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 65535));
    cycle();
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h41 || imem_wdata !== 16'hB800) begin
      n_err++; $display("FAIL jump_nop: we=%b addr=%h wdata=%h, required 1 41 b800", imem_we, imem_addr, imem_wdata);
    end
    end_session();
  endtask

  task automatic test_reject();
    begin_session(16'h00);
    set_tuple(0, 0, 1, 1, 0, 64);
    cycle();
    n_vec++;
    if (imem_we !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reject_imm64: we=%b rdy=%b, required 0 1", imem_we, in_ready);
    end
    set_tuple(3, 5, 2, 2, 2, 0);
    cycle();
    n_vec++;
    if (imem_we !== 1'b0 || err !== 1'b1 || err_count !== 8'd2 || word_count !== 9'd0) begin
      n_err++;
      $display("FAIL reject_class3: we=%b err=%b errc=%0d wc=%0d, required 0 1 2 0", imem_we, err, err_count, word_count);
    end
    set_tuple(0, 0, 0, 0, 0, 16'hFFC0);
    cycle();
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 16'h0040) begin
      n_err++; $display("FAIL reject_imm_min: we=%b addr=%h wdata=%h, required 1 00 0040", imem_we, imem_addr, imem_wdata);
    end
    set_tuple(0, 0, 0, 0, 0, 63);
    cycle();
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h01 || imem_wdata !== 16'h003F) begin
      n_err++; $display("FAIL reject_imm_max: we=%b addr=%h wdata=%h, required 1 01 003f", imem_we, imem_addr, imem_wdata);
    end
    set_tuple(0, 0, 0, 0, 0, 16'hFFBF);
    cycle();
    n_vec++;
    if (imem_we !== 1'b0 || err_count !== 8'd3) begin
      n_err++; $display("FAIL reject_imm_m65: we=%b errc=%0d, required 0 3", imem_we, err_count);
    end
    set_tuple(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 258; i++) cycle();
    n_vec++;
    if (err_count !== 8'd255 || word_count !== 9'd2 || err !== 1'b1) begin
      n_err++; $display("FAIL reject_saturate: errc=%0d wc=%0d err=%b, required 255 2 1", err_count, word_count, err);
    end
    end_session();
    begin_session(16'h00);
    n_vec++;
    if (err !== 1'b0 || err_count !== 8'd0 || word_count !== 9'd0) begin
      n_err++; $display("FAIL reject_cleared: err=%b errc=%0d wc=%0d, required 0 0 0", err, err_count, word_count);
    end
    end_session();
  endtask

  task automatic test_full_wrap();
    begin_session(16'hFE);
    set_tuple(1, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec++;
      if (i < 4) begin
        if (imem_we !== 1'b1 || imem_addr !== 8'(8'hFE + i)) begin
          n_err++; $display("FAIL full_write%0d: we=%b addr=%h, required 1 %h", i, imem_we, imem_addr, 8'(8'hFE + i));
        end
      end else if (imem_we !== 1'b0) begin
        n_err++; $display("FAIL full_fifth: we=%b, required 0", imem_we);
      end
      if (i == 3) begin
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || word_count !== 9'd4) begin
          n_err++; $display("FAIL full_state: rdy=%b busy=%b wc=%0d, required 0 1 4", in_ready, busy, word_count);
        end
      end
    end
    end_session();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL full_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    begin_session(16'h30);
    set_tuple(1, 3, 1, 1, 1, 0);
    cycle();
    in_valid = 0;
    rst_n = 0;
    #1;
    n_vec++;
    if (imem_we !== 1'b0) begin n_err++; $display("FAIL abort_we: we=%b, required 0", imem_we); end
    cycle();
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata, busy, done, err, err_count, word_count, in_ready} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: we=%b addr=%h wdata=%h busy=%b done=%b wc=%0d rdy=%b, all required 0",
               imem_we, imem_addr, imem_wdata, busy, done, word_count, in_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_finish_same_cycle();
    begin_session(16'h50);
    set_tuple(2, 0, 1, 2, 3, 0);
    finish = 1;
    cycle();
    finish = 0; in_valid = 0;
    n_vec++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h50 || imem_wdata !== 16'h8264 || done !== 1'b1 || word_count !== 9'd1) begin
      n_err++;
      $display("FAIL fin_same: we=%b addr=%h wdata=%h done=%b wc=%0d, required 1 50 8264 1 1",
               imem_we, imem_addr, imem_wdata, done, word_count);
    end
`ifdef INSTR_ENCODER_CHECKSUM_EN
    n_vec++;
    if (checksum !== 16'h8264) begin n_err++; $display("FAIL fin_checksum: got %h, required 8264", checksum); end
`endif
    cycle();
    n_vec++;
    if (imem_we !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL fin_after: we=%b done=%b, required 0 1", imem_we, done);
    end
  endtask

  task automatic test_random();
    int simm;
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      start     = ($urandom_range(0, 9) == 0);
      finish    = ($urandom_range(0, 19) == 0);
      base_addr = 8'($urandom_range(0, 255));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_class  = 2'($urandom_range(0, 3));
      in_op     = 4'($urandom_range(0, 15));
      in_rd     = 3'($urandom_range(0, 7));
      in_rs1    = 3'($urandom_range(0, 7));
      in_rs2    = 3'($urandom_range(0, 7));
      simm      = int'($urandom_range(0, 140)) - 70;
      in_imm    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'(simm);
      cycle();
      n_vec++;
      if (imem_we !== m_we || (m_we && (imem_addr !== 8'(m_addr) || imem_wdata !== 16'(m_wdata)))) begin
        n_err++;
        $display("FAIL rand_write @%0d: we=%b addr=%h wdata=%h, required %b %h %h",
                 n, imem_we, imem_addr, imem_wdata, m_we, 8'(m_addr), 16'(m_wdata));
      end
      n_vec++;
      if (in_ready !== (m_st == M_LOAD) || busy !== (m_st == M_LOAD || m_st == M_FULL) || done !== (m_st == M_DONE)) begin
        n_err++;
        $display("FAIL rand_state @%0d: rdy=%b busy=%b done=%b, model state %0d", n, in_ready, busy, done, m_st);
      end
      n_vec++;
      if (err !== m_err || err_count !== 8'(m_errc) || word_count !== 9'(m_wc)) begin
        n_err++;
        $display("FAIL rand_counts @%0d: err=%b errc=%0d wc=%0d, required %b %0d %0d",
                 n, err, err_count, word_count, m_err, m_errc, m_wc);
      end
`ifdef INSTR_ENCODER_CHECKSUM_EN
      n_vec++;
      if (checksum !== 16'(m_ck)) begin
        n_err++; $display("FAIL rand_checksum @%0d: got %h, required %h", n, checksum, 16'(m_ck));
      end
`endif
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_jump_special();
    test_reject();
    test_full_wrap();
    test_reset_abort();
    test_finish_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
